// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Moore control FSM for a multi-cycle MIPS-like datapath. Sequences
//   fetch / decode / execute / memory / writeback and raises one set of
//   control strobes per state. Opcode/funct are captured at the end of ID so
//   later states do not depend on the IR contents.
//
//   Parameters
//     MEM_WAIT_MAX  max cycles spent in MEM_RD/MEM_WR waiting for MemReady
//                   (must be >= 1)
//
//   Ports
//     CLK, Reset            clock, synchronous active-high reset
//     opcode, funct         live IR fields (decoded in ID only)
//     Zero                  ALU zero flag (used in BR)
//     MemReady              data memory done (used in MEM states only)
//     PCWrite, PCSrc        PC load enable / source select
//     IRWrite               IR load enable
//     RegWrite, RegDst      RegFile write enable / dest select (1 = rd)
//     MemtoReg              writeback source (1 = data memory)
//     ALUSrcB, ExtSel       immediate operand select / sign-extend
//     ALUOp                 000 add, 001 sub, 010 and, 011 or, 100 slt
//     mRD, mWR              data memory read / write
//     IllegalOp, MemErr     one-cycle error pulses
//     Halted                level, high while in HALT
//     state                 current state (debug)
//     cycle_cnt, instr_cnt  performance counters
//
//   Build option
//     CTRL_PERF_CNT_EN  when defined, cycle_cnt/instr_cnt are live counters;
//                       otherwise both read 0 and no counter flops exist.
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcB,
  output logic        ExtSel,
  output logic [2:0]  ALUOp,
  output logic        mRD,
  output logic        mWR,
  output logic        IllegalOp,
  output logic        MemErr,
  output logic        Halted,
  output logic [3:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE    = 4'd2,
    S_WB_ALU = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_BR     = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_R, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_HALT
  } cls_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Wait counter only has to reach MEM_WAIT_MAX-1: that is the last cycle
  // in which a missing MemReady turns into an abort.
  localparam int            WW        = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

  function automatic cls_e decode(input logic [5:0] op, input logic [5:0] fn);
    cls_e c;
    c = C_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: c = C_R;
          default: c = C_ILL;
        endcase
      end
      6'b001000: c = C_ADDI;
      6'b001101: c = C_ORI;
      6'b100011: c = C_LW;
      6'b101011: c = C_SW;
      6'b000100: c = C_BEQ;
      6'b000101: c = C_BNE;
      6'b000010: c = C_J;
      6'b111111: c = C_HALT;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] alu_sel(input cls_e c, input logic [5:0] fn);
    logic [2:0] a;
    a = ALU_ADD;
    if (c == C_ORI) begin
      a = ALU_OR;
    end else if (c == C_R) begin
      case (fn)
        6'b100010: a = ALU_SUB;
        6'b100100: a = ALU_AND;
        6'b100101: a = ALU_OR;
        6'b101010: a = ALU_SLT;
        default:   a = ALU_ADD;
      endcase
    end
    return a;
  endfunction

  state_e        state_q, state_d;
  logic [5:0]    op_q, op_d;
  logic [5:0]    fn_q, fn_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          mem_err_q, mem_err_d;
  logic          in_mem;
  logic          mem_abort;
  cls_e          cls_live;
  cls_e          cls_q;

  // ID decodes the IR as it sits now; later states use the captured copy.
  assign cls_live = decode(opcode, funct);
  assign cls_q    = decode(op_q, fn_q);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    fn_d      = fn_q;
    wait_d    = '0;
    mem_abort = 1'b0;
    in_mem    = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    // Counter is zero whenever we are outside MEM, so it is clear on entry.
    if (in_mem && !MemReady) begin
      wait_d    = wait_q + WW'(1);
      mem_abort = (wait_q == WAIT_LAST);
    end

    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        op_d = opcode;
        fn_d = funct;
        case (cls_live)
          C_HALT:              state_d = S_HALT;
          C_R, C_ADDI, C_ORI:  state_d = S_EXE;
          C_LW, C_SW:          state_d = S_ADDR;
          C_BEQ, C_BNE:        state_d = S_BR;
          default:             state_d = S_IF;   // j and illegal
        endcase
      end
      S_EXE:    state_d = S_WB_ALU;
      S_WB_ALU: state_d = S_IF;
      S_ADDR:   state_d = (cls_q == C_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (MemReady)       state_d = S_WB_MEM;
        else if (mem_abort) state_d = S_IF;
      end
      S_MEM_WR: begin
        if (MemReady || mem_abort) state_d = S_IF;
      end
      S_WB_MEM: state_d = S_IF;
      S_BR:     state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase

    // MemErr is registered so the output never depends on MemReady.
    mem_err_d = mem_abort;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_IF;
      op_q      <= '0;
      fn_q      <= '0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Moore outputs; Reset forces everything low.
  always_comb begin
    PCWrite   = 1'b0;
    PCSrc     = 2'b00;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;
    IllegalOp = 1'b0;
    MemErr    = mem_err_q;
    Halted    = 1'b0;
    state     = state_q;

    case (state_q)
      S_IF: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_ID: begin
        if (cls_live == C_J) begin
          PCWrite = 1'b1;
          PCSrc   = 2'b10;
        end else if (cls_live == C_ILL) begin
          IllegalOp = 1'b1;
        end
      end
      S_EXE, S_WB_ALU: begin
        ALUOp   = alu_sel(cls_q, fn_q);
        ALUSrcB = (cls_q == C_ADDI) || (cls_q == C_ORI);
        ExtSel  = (cls_q == C_ADDI);
        if (state_q == S_WB_ALU) begin
          RegWrite = 1'b1;
          RegDst   = (cls_q == C_R);
        end
      end
      S_ADDR: begin
        ALUOp   = ALU_ADD;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
      end
      S_MEM_RD: mRD = 1'b1;
      S_MEM_WR: mWR = 1'b1;
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_BR: begin
        ALUOp   = ALU_SUB;
        PCSrc   = 2'b01;
        PCWrite = (cls_q == C_BNE) ? !Zero : Zero;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase

    if (Reset) begin
      PCWrite   = 1'b0;
      PCSrc     = 2'b00;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = ALU_ADD;
      mRD       = 1'b0;
      mWR       = 1'b0;
      IllegalOp = 1'b0;
      MemErr    = 1'b0;
      Halted    = 1'b0;
      state     = 4'd0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;
  logic        instr_done;

  // An instruction retires on its last cycle before IF; illegal opcodes and
  // memory timeouts never retire.
  always_comb begin
    instr_done = 1'b0;
    case (state_q)
      S_ID:                   instr_done = (cls_live == C_J);
      S_WB_ALU, S_WB_MEM,
      S_BR:                   instr_done = 1'b1;
      S_MEM_WR:               instr_done = MemReady;
      default:                instr_done = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = Reset ? 32'd0 : cycle_cnt_q;
  assign instr_cnt = Reset ? 32'd0 : instr_cnt_q;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//   Directed bench for multi_cycle_ctrl. Each instruction is expanded into
//   its cycle sequence from the CPI rules (IF, ID, then class-specific
//   cycles); per cycle the expected strobes come from the state table and a
//   single negedge process compares every DUT output. A few literal
//   expectations (strobe counts, perf counter values) pin the model.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

  localparam int MAXW = 15;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ORI = 6'h0D,
                         OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_J = 6'h02, OP_HALT = 6'h3F,
                         OP_BAD = 6'h33;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_OR = 6'h25, F_SLT = 6'h2A;

  localparam int K_ILL = 0, K_R = 1, K_ADDI = 2, K_ORI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_BNE = 7, K_J = 8, K_HALT = 9;

  logic        CLK;
  logic        Reset;
  logic [5:0]  opcode, funct;
  logic        Zero, MemReady;
  logic        PCWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcB, ExtSel;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp;
  logic        mRD, mWR, IllegalOp, MemErr, Halted;
  logic [3:0]  state;
  logic [31:0] cycle_cnt, instr_cnt;

  multi_cycle_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .IllegalOp(IllegalOp), .MemErr(MemErr), .Halted(Halted), .state(state),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---- model state --------------------------------------------------------
  logic [16:0] exp_ctl;
  logic [3:0]  exp_st;
  logic [31:0] exp_cyc, exp_ins;
  bit          exp_vld = 1'b0;
  int          m_cyc = 0, m_ins = 0;
  bit          pend = 1'b0;     // MemErr expected in the next cycle
  int          cut_left = -1;   // cycles left before a forced reset (-1 = none)

  int obs_rw = 0, obs_mrd = 0, obs_err = 0, obs_halt = 0;

  function automatic int bcls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R:    return (fn == F_ADD || fn == F_SUB || fn == F_AND ||
                       fn == F_OR  || fn == F_SLT) ? K_R : K_ILL;
      OP_ADDI: return K_ADDI;
      OP_ORI:  return K_ORI;
      OP_LW:   return K_LW;
      OP_SW:   return K_SW;
      OP_BEQ:  return K_BEQ;
      OP_BNE:  return K_BNE;
      OP_J:    return K_J;
      OP_HALT: return K_HALT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] balu(input int c, input logic [5:0] fn);
    if (c == K_ORI) return 3'b011;
    if (c != K_R)   return 3'b000;
    case (fn)
      F_SUB:   return 3'b001;
      F_AND:   return 3'b010;
      F_OR:    return 3'b011;
      F_SLT:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Strobes for one cycle, packed in DUT port order (MemErr slot left 0).
  function automatic logic [16:0] model_ctl(input int st, input int c,
                                            input logic [5:0] fn, input logic z);
    logic pcw, irw, rw, rdst, m2r, srcb, ext, mrd, mwr, ill, hlt;
    logic [1:0] pcs;
    logic [2:0] aop;
    {pcw, irw, rw, rdst, m2r, srcb, ext, mrd, mwr, ill, hlt} = '0;
    pcs = 2'b00;
    aop = 3'b000;
    case (st)
      0: begin irw = 1'b1; pcw = 1'b1; end
      1: begin
        if (c == K_J) begin pcw = 1'b1; pcs = 2'b10; end
        else if (c == K_ILL) ill = 1'b1;
      end
      2, 3: begin
        aop  = balu(c, fn);
        srcb = (c == K_ADDI) || (c == K_ORI);
        ext  = (c == K_ADDI);
        if (st == 3) begin rw = 1'b1; rdst = (c == K_R); end
      end
      4: begin srcb = 1'b1; ext = 1'b1; end
      5: mrd = 1'b1;
      6: mwr = 1'b1;
      7: begin rw = 1'b1; m2r = 1'b1; end
      8: begin aop = 3'b001; pcs = 2'b01; pcw = (c == K_BEQ) ? z : !z; end
      9: hlt = 1'b1;
      default: ;
    endcase
    return {pcw, pcs, irw, rw, rdst, m2r, srcb, ext, aop, mrd, mwr, ill, 1'b0, hlt};
  endfunction

  // One clock cycle: drive inputs, publish the expectation, advance.
  task automatic step(input int st, input int c, input logic [5:0] op,
                      input logic [5:0] fn, input logic z, input logic rdy);
    logic [16:0] e;
    if (cut_left == 0) return;
    if (cut_left > 0) cut_left--;
    e       = model_ctl(st, c, fn, z);
    e[1]    = pend;
    exp_ctl = e;
    exp_st  = 4'(st);
    exp_cyc = PERF ? 32'(m_cyc) : 32'd0;
    exp_ins = PERF ? 32'(m_ins) : 32'd0;
    Reset   = 1'b0;
    // After ID the IR fields are scrambled: the DUT must use its own copy.
    opcode   = (st <= 1) ? op : ~op;
    funct    = (st <= 1) ? fn : ~fn;
    Zero     = z;
    MemReady = rdy;
    exp_vld  = 1'b1;
    @(posedge CLK); #1;
    pend = 1'b0;
    m_cyc++;
  endtask

  // rdy_at: MEM cycle index carrying MemReady (-1 never); HALT dwell for halt.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int rdy_at);
    int  c;
    bit  done;
    bit  ok;
    logic r;
    c    = bcls(op, fn);
    done = 1'b0;
    step(0, c, op, fn, z, 1'b1);
    step(1, c, op, fn, z, 1'b1);
    case (c)
      K_R, K_ADDI, K_ORI: begin
        step(2, c, op, fn, z, 1'b1);
        step(3, c, op, fn, z, 1'b1);
        done = 1'b1;
      end
      K_LW, K_SW: begin
        step(4, c, op, fn, z, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
          r = (k == rdy_at);
          step((c == K_LW) ? 5 : 6, c, op, fn, z, r);
          if (r) begin ok = 1'b1; break; end
        end
        if (ok && c == K_LW) step(7, c, op, fn, z, 1'b1);
        if (!ok && cut_left != 0) pend = 1'b1;
        done = ok;
      end
      K_BEQ, K_BNE: begin
        step(8, c, op, fn, z, 1'b1);
        done = 1'b1;
      end
      K_J: done = 1'b1;
      K_HALT: for (int k = 0; k < rdy_at; k++) step(9, c, op, fn, z, 1'b1);
      default: done = 1'b0;
    endcase
    if (done && cut_left != 0) m_ins++;
  endtask

  task automatic rst_cycle();
    exp_ctl  = '0;
    exp_st   = 4'd0;
    exp_cyc  = 32'd0;
    exp_ins  = 32'd0;
    Reset    = 1'b1;
    opcode   = OP_HALT;
    funct    = 6'h3F;
    Zero     = 1'b1;
    MemReady = 1'b1;
    exp_vld  = 1'b1;
    @(posedge CLK); #1;
    m_cyc = 0; m_ins = 0; pend = 1'b0; cut_left = -1;
  endtask

  // ---- compare process ----------------------------------------------------
  always @(negedge CLK) begin
    if (exp_vld) begin
      chk("ctrl", 32'({PCWrite, PCSrc, IRWrite, RegWrite, RegDst, MemtoReg,
                       ALUSrcB, ExtSel, ALUOp, mRD, mWR, IllegalOp, MemErr,
                       Halted}), 32'(exp_ctl));
      chk("state", 32'(state), 32'(exp_st));
      chk("cycle_cnt", cycle_cnt, exp_cyc);
      chk("instr_cnt", instr_cnt, exp_ins);
      obs_rw   += int'(RegWrite);
      obs_mrd  += int'(mRD);
      obs_err  += int'(MemErr);
      obs_halt += int'(Halted);
    end
  end

  // ---- directed program ---------------------------------------------------
  int rw0, mrd0, err0, h0;

  initial begin
    Reset = 1'b1; opcode = '0; funct = '0; Zero = 1'b0; MemReady = 1'b0;
    rst_cycle();
    rst_cycle();

    // add, j, beq not taken: 9 cycles, 3 instructions
    rw0 = obs_rw;
    run_instr(OP_R, F_ADD, 1'b0, 0);
    chk("add_regwrite_once", 32'(obs_rw - rw0), 32'd1);
    run_instr(OP_J, 6'h11, 1'b0, 0);
    run_instr(OP_BEQ, 6'h07, 1'b0, 0);
    chk("perf_instr", instr_cnt, PERF ? 32'd3 : 32'd0);
    chk("perf_cycle", cycle_cnt, PERF ? 32'd9 : 32'd0);

    run_instr(OP_R, F_SUB, 1'b0, 0);
    run_instr(OP_R, F_AND, 1'b1, 0);
    run_instr(OP_R, F_OR,  1'b0, 0);
    run_instr(OP_R, F_SLT, 1'b0, 0);
    run_instr(OP_ADDI, 6'h15, 1'b0, 0);
    run_instr(OP_ORI,  6'h2A, 1'b0, 0);

    // lw with MemReady 3 cycles after MEM_RD entry
    rw0 = obs_rw; mrd0 = obs_mrd;
    run_instr(OP_LW, 6'h00, 1'b0, 3);
    chk("lw_mrd_cycles", 32'(obs_mrd - mrd0), 32'd4);
    chk("lw_regwrite_once", 32'(obs_rw - rw0), 32'd1);
    run_instr(OP_LW, 6'h01, 1'b0, 0);
    run_instr(OP_SW, 6'h02, 1'b0, 0);
    run_instr(OP_SW, 6'h03, 1'b0, MAXW - 1);   // ready on the last allowed cycle

    run_instr(OP_BEQ, 6'h00, 1'b1, 0);
    run_instr(OP_BNE, 6'h00, 1'b1, 0);
    run_instr(OP_BNE, 6'h00, 1'b0, 0);

    // sw timeout
    rw0 = obs_rw; err0 = obs_err;
    run_instr(OP_SW, 6'h04, 1'b0, -1);
    chk("sw_timeout_no_regwrite", 32'(obs_rw - rw0), 32'd0);
    run_instr(OP_R, F_ADD, 1'b0, 0);
    chk("sw_timeout_memerr_once", 32'(obs_err - err0), 32'd1);

    run_instr(OP_BAD, 6'h00, 1'b0, 0);
    run_instr(OP_R, 6'h01, 1'b0, 0);            // R-type, undefined funct
    run_instr(OP_ADDI, 6'h00, 1'b0, 0);

    // reset in the middle of a lw memory wait
    rw0 = obs_rw;
    cut_left = 6;
    run_instr(OP_LW, 6'h05, 1'b0, -1);
    rst_cycle();
    chk("lw_reset_no_regwrite", 32'(obs_rw - rw0), 32'd0);
    run_instr(OP_R, F_SUB, 1'b0, 0);

    // halt for 20 cycles, then reset
    h0 = obs_halt;
    run_instr(OP_HALT, 6'h00, 1'b0, 20);
    chk("halt_dwell", 32'(obs_halt - h0), 32'd20);
    rst_cycle();
    run_instr(OP_R, F_ADD, 1'b0, 0);
    chk("post_halt_cycle", cycle_cnt, PERF ? 32'd4 : 32'd0);

    exp_vld = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
